// File: rtl/alu.sv
// Registered 32-bit RV32I ALU: sixteen arithmetic/logic/shift/compare ops, one-cycle latency.
// Define ALU_BRANCH_CMP_EN to build the branch-compare codes 9-12, 14, 15.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic [5:0]  aluCtrl,
    output logic [31:0] aluOut
);

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_XOR  = 6'd2;
    localparam logic [5:0] OP_SLL  = 6'd3;
    localparam logic [5:0] OP_SLT  = 6'd4;
    localparam logic [5:0] OP_SRL  = 6'd5;
    localparam logic [5:0] OP_SRA  = 6'd6;
    localparam logic [5:0] OP_AND  = 6'd7;
    localparam logic [5:0] OP_OR   = 6'd8;
    localparam logic [5:0] OP_SLTU = 6'd13;
`ifdef ALU_BRANCH_CMP_EN
    localparam logic [5:0] OP_BEQ  = 6'd9;
    localparam logic [5:0] OP_BNE  = 6'd10;
    localparam logic [5:0] OP_BLT  = 6'd11;
    localparam logic [5:0] OP_BGE  = 6'd12;
    localparam logic [5:0] OP_BLTU = 6'd14;
    localparam logic [5:0] OP_BGEU = 6'd15;
`endif

    logic [4:0]  shamt;
    logic        lt;
    logic        ltu;
    logic [31:0] res;

    assign shamt = srcb[4:0];
    assign lt    = $signed(srca) < $signed(srcb);
    assign ltu   = srca < srcb;

    // Flags land in bit 0; upper bits stay zero.
    always_comb begin
        res = 32'h0000_0000;
        case (aluCtrl)
            OP_ADD:  res = srca + srcb;
            OP_SUB:  res = srca - srcb;
            OP_XOR:  res = srca ^ srcb;
            OP_SLL:  res = srca << shamt;
            OP_SLT:  res = {31'd0, lt};
            OP_SRL:  res = srca >> shamt;
            OP_SRA:  res = $signed(srca) >>> shamt;
            OP_AND:  res = srca & srcb;
            OP_OR:   res = srca | srcb;
            OP_SLTU: res = {31'd0, ltu};
`ifdef ALU_BRANCH_CMP_EN
            OP_BEQ:  res = {31'd0, srca == srcb};
            OP_BNE:  res = {31'd0, srca != srcb};
            OP_BLT:  res = {31'd0, lt};
            OP_BGE:  res = {31'd0, ~lt};
            OP_BLTU: res = {31'd0, ltu};
            OP_BGEU: res = {31'd0, ~ltu};
`endif
            default: res = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) aluOut <= 32'h0000_0000;
        else        aluOut <= res;
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: vector table plus random ops through a scoreboard queue,
// hand-written reset sequences. Branch expectations follow ALU_BRANCH_CMP_EN.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [5:0]  aluCtrl;
    logic [31:0] aluOut;

    alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .srca    (srca),
        .srcb    (srcb),
        .aluCtrl (aluCtrl),
        .aluOut  (aluOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   passed = 0;
    int   total  = 0;

`ifdef ALU_BRANCH_CMP_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    function automatic logic [31:0] br(input logic [31:0] v);
        return BR ? v : 32'd0;
    endfunction

    // Reference built from different primitives than the DUT: bias-flip for signed
    // compares, complement trick for arithmetic shift.
    function automatic logic [31:0] model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sa;
        logic [31:0] sb;
        logic [4:0]  sh;
        sa = a ^ 32'h8000_0000;
        sb = b ^ 32'h8000_0000;
        sh = b[4:0];
        case (c)
            6'd0:  return a + b;
            6'd1:  return a + ~b + 32'd1;
            6'd2:  return (a | b) & ~(a & b);
            6'd3:  return a * (32'd1 << sh);
            6'd4:  return (sa < sb) ? 32'd1 : 32'd0;
            6'd5:  return a / (32'd1 << sh);
            6'd6:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            6'd7:  return ~(~a | ~b);
            6'd8:  return ~(~a & ~b);
            6'd9:  return br((a == b) ? 32'd1 : 32'd0);
            6'd10: return br((a == b) ? 32'd0 : 32'd1);
            6'd11: return br((sa < sb) ? 32'd1 : 32'd0);
            6'd12: return br((sa < sb) ? 32'd0 : 32'd1);
            6'd13: return (a < b) ? 32'd1 : 32'd0;
            6'd14: return br((a < b) ? 32'd1 : 32'd0);
            6'd15: return br((a < b) ? 32'd0 : 32'd1);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        sb_t e;
        @(negedge clk);
        aluCtrl = c;
        srca    = a;
        srcb    = b;
        e.exp   = exp;
        e.name  = name;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            total++;
            $display("FAIL drain: %0d results never appeared, expected 0 pending", sbq.size());
            sbq.delete();
        end
    endtask

    // Each result is checked just after the edge that follows its issue.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.name, aluOut, e.exp);
        end
    end

    initial begin
        rst_n   = 1'b0;
        srca    = 32'd21;
        srcb    = 32'd10;
        aluCtrl = 6'd0;

        // Held in reset: edges must not capture anything.
        repeat (3) @(posedge clk);
        #1 check("reset_hold", aluOut, 32'd0);
        @(negedge clk);
        check("reset_hold_neg", aluOut, 32'd0);
        rst_n = 1'b1;
        sbq.push_back('{exp: 32'd31, name: "first_after_reset"});
        drain();

        vecs.push_back('{6'd0,  32'd21, 32'd10, 32'd31,    "add_21_10"});
        vecs.push_back('{6'd1,  32'd21, 32'd10, 32'd11,    "sub_21_10"});
        vecs.push_back('{6'd2,  32'd21, 32'd10, 32'd31,    "xor_21_10"});
        vecs.push_back('{6'd3,  32'd21, 32'd10, 32'd21504, "sll_21_10"});
        vecs.push_back('{6'd4,  32'd21, 32'd10, 32'd0,     "slt_21_10"});
        vecs.push_back('{6'd5,  32'd21, 32'd10, 32'd0,     "srl_21_10"});
        vecs.push_back('{6'd6,  32'd21, 32'd10, 32'd0,     "sra_21_10"});
        vecs.push_back('{6'd7,  32'd21, 32'd10, 32'd0,     "and_21_10"});
        vecs.push_back('{6'd8,  32'd21, 32'd10, 32'd31,    "or_21_10"});
        vecs.push_back('{6'd6,  32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFFF, "sra_neg"});
        vecs.push_back('{6'd5,  32'hFFFF_FFF0, 32'd4, 32'h0FFF_FFFF, "srl_neg"});
        vecs.push_back('{6'd4,  32'hFFFF_FFF0, 32'd4, 32'd1,     "slt_neg"});
        vecs.push_back('{6'd13, 32'hFFFF_FFF0, 32'd4, 32'd0,     "sltu_neg"});
        vecs.push_back('{6'd11, 32'hFFFF_FFF0, 32'd4, br(32'd1), "blt_neg"});
        vecs.push_back('{6'd14, 32'hFFFF_FFF0, 32'd4, 32'd0,     "bltu_neg"});
        vecs.push_back('{6'd15, 32'hFFFF_FFF0, 32'd4, br(32'd1), "bgeu_neg"});
        vecs.push_back('{6'd12, 32'hFFFF_FFF0, 32'd4, 32'd0,     "bge_neg"});
        vecs.push_back('{6'd9,  32'd7, 32'd7, br(32'd1), "beq_eq"});
        vecs.push_back('{6'd10, 32'd7, 32'd7, 32'd0,     "bne_eq"});
        vecs.push_back('{6'd12, 32'd7, 32'd7, br(32'd1), "bge_eq"});
        vecs.push_back('{6'd15, 32'd7, 32'd7, br(32'd1), "bgeu_eq"});
        vecs.push_back('{6'd10, 32'd7, 32'd8, br(32'd1), "bne_ne"});
        vecs.push_back('{6'd14, 32'd3, 32'hFFFF_FFFF, br(32'd1), "bltu_big"});
        vecs.push_back('{6'd3,  32'd1, 32'd33, 32'd2,    "sll_shamt_wrap"});
        vecs.push_back('{6'd16, 32'd21, 32'd10, 32'd0,   "code16"});
        vecs.push_back('{6'd63, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, "code63"});
        vecs.push_back('{6'd0,  32'hFFFF_FFFF, 32'd1, 32'd0, "add_wrap"});
        vecs.push_back('{6'd1,  32'd0, 32'd1, 32'hFFFF_FFFF, "sub_wrap"});

        foreach (vecs[i]) issue(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        drain();

        for (int i = 0; i < 60; i++) begin
            logic [5:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            c = (i % 5 == 4) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
            a = $urandom;
            b = (i % 3 == 0) ? a : $urandom;
            issue(c, a, b, model(c, a, b), $sformatf("rand_%0d_op%0d", i, c));
        end
        drain();

        // Back-to-back issue, then an asynchronous reset pulse between edges.
        issue(6'd0, 32'd5, 32'd3, 32'd8, "b2b_add");
        issue(6'd1, 32'd5, 32'd3, 32'd2, "b2b_sub");
        drain();
        #2 rst_n = 1'b0;
        #1 check("async_reset_clear", aluOut, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset arriving while an op is pending discards it.
        @(negedge clk);
        aluCtrl = 6'd0;
        srca    = 32'd5;
        srcb    = 32'd3;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 check("pending_discarded", aluOut, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sbq.push_back('{exp: 32'd8, name: "resume_after_reset"});
        drain();

        // Inputs changing between edges leave the register alone.
        @(negedge clk);
        aluCtrl = 6'd1;
        srca    = 32'd100;
        #1 check("hold_between_edges", aluOut, 32'd8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
